// File: rtl/regmap_gen_pkg.sv
// Shared types and helpers for the regmap_gen register block.
// Holds the per-register access kind and the byte-lane count helper.
// No logic; imported by the interface, the register cell and the top.
package regmap_gen_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2
  } acc_t;

  // Number of byte lanes in a data word (data width is a multiple of 8).
  function automatic int unsigned lane_cnt(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/regmap_gen_if.sv
// Register access bus: write/read strobes, address, data, byte enables, response.
// Requests are single-cycle strobes; responses arrive one cycle later.
// No backpressure: every strobe is accepted on the cycle it is high.
interface regmap_gen_if
  import regmap_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic                              i_wren;
  logic                              i_rden;
  logic [ADDR_WIDTH-1:0]             i_addr;
  logic [DATA_WIDTH-1:0]             i_wrdata;
  logic [lane_cnt(DATA_WIDTH)-1:0]   i_be;
  logic                              o_rdvalid;
  logic [DATA_WIDTH-1:0]             o_rddata;
  logic                              o_err;

  modport master (
    output i_wren, i_rden, i_addr, i_wrdata, i_be,
    input  o_rdvalid, o_rddata, o_err
  );

  modport slave (
    input  i_wren, i_rden, i_addr, i_wrdata, i_be,
    output o_rdvalid, o_rddata, o_err
  );

endinterface

// File: rtl/regmap_gen_reg.sv
// One register cell: byte-enabled RW storage, W1C sticky status, or plain RO (no storage).
// Latency: write lands at the rising edge where wr_en is high; q reflects it next cycle.
// No backpressure: wr_en is a qualified, always-accepted write.
module regmap_gen_reg
  import regmap_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter acc_t                  ACC        = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [lane_cnt(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]           set_in,
  output logic [DATA_WIDTH-1:0]           q
);

  localparam int LANES = lane_cnt(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] be_mask;

  // Expand byte enables into a per-bit mask.
  always_comb begin
    be_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      be_mask[8*k +: 8] = {8{be[k]}};
    end
  end

  if (ACC == ACC_RW) begin : g_rw
    logic [DATA_WIDTH-1:0] val_d, val_q;
    logic                  unused_rw;
    assign unused_rw = ^set_in;

    // Merge enabled bytes of the write data over the current value.
    always_comb begin
      val_d = val_q;
      if (wr_en) begin
        val_d = (val_q & ~be_mask) | (wr_data & be_mask);
      end
    end

    // Register storage, reset to the configured RW reset value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= RST_VAL;
      else        val_q <= val_d;
    end

    assign q = val_q;
  end else if (ACC == ACC_W1C) begin : g_w1c
    logic [DATA_WIDTH-1:0] val_d, val_q;
    logic [DATA_WIDTH-1:0] clr;

    // Sticky bits: clear on written ones, then OR in new events so set wins.
    always_comb begin
      clr   = wr_en ? (wr_data & be_mask) : '0;
      val_d = (val_q & ~clr) | set_in;
    end

    // Sticky status storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
    end

    assign q = val_q;
  end else begin : g_ro
    // Plain RO: the top reads the live source directly; nothing is stored here.
    logic unused_ro;
    assign unused_ro = ^{clk, rst_n, wr_en, wr_data, be_mask, set_in};
    assign q = '0;
  end

endmodule

// File: rtl/regmap_gen.sv
// Parameterised register map: RW registers plus RO inputs (sticky W1C status with REGMAP_GEN_W1C_EN).
// Latency: read data, o_rdvalid, o_err and o_wr_pulse appear one cycle after the strobe.
// No backpressure: one access per strobe cycle, back-to-back reads stream without bubbles.
module regmap_gen
  import regmap_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = NUM_REGS'(8'hAA),
  parameter logic [DATA_WIDTH-1:0] RW_RST     = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  regmap_gen_if.slave                    bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_rw_regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro_regs,
  output logic [NUM_REGS-1:0]            o_wr_pulse
);

`ifdef REGMAP_GEN_W1C_EN
  localparam acc_t                RO_KIND = ACC_W1C;
  localparam logic [NUM_REGS-1:0] WR_OK   = {NUM_REGS{1'b1}};
`else
  localparam acc_t                RO_KIND = ACC_RO;
  localparam logic [NUM_REGS-1:0] WR_OK   = ~RO_MASK;
`endif

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_rd;

  logic [NUM_REGS-1:0]   sel;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [NUM_REGS-1:0]   wr_en_vec;
  logic                  wr_acc;

  logic                  rdvalid_d, rdvalid_q;
  logic [DATA_WIDTH-1:0] rddata_d, rddata_q;
  logic                  err_d, err_q;
  logic [NUM_REGS-1:0]   wr_pulse_d, wr_pulse_q;

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    localparam acc_t KIND = RO_MASK[n] ? RO_KIND : ACC_RW;

    regmap_gen_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC        (KIND),
      .RST_VAL    (RW_RST)
    ) u_reg (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .wr_en   (wr_en_vec[n]),
      .wr_data (bus.i_wrdata),
      .be      (bus.i_be),
      .set_in  (i_ro_regs[n*DATA_WIDTH +: DATA_WIDTH]),
      .q       (reg_q[n])
    );

    if (KIND == ACC_RO) begin : g_ro_src
      logic unused_q;
      assign unused_q  = ^reg_q[n];
      assign reg_rd[n] = i_ro_regs[n*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_q_src
      assign reg_rd[n] = reg_q[n];
    end

    // Only RW registers are exported; status registers show zero here.
    assign o_rw_regs[n*DATA_WIDTH +: DATA_WIDTH] = (KIND == ACC_RW) ? reg_q[n] : '0;
  end

  // Address decode, read mux (pre-write values), write qualification and response terms.
  always_comb begin
    sel    = '0;
    rd_val = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (bus.i_addr == ADDR_WIDTH'(n)) begin
        sel[n] = 1'b1;
        rd_val = reg_rd[n];
      end
    end
    addr_ok    = |sel;
    wr_en_vec  = bus.i_wren ? (sel & WR_OK) : '0;
    wr_acc     = |wr_en_vec;
    rdvalid_d  = bus.i_rden;
    rddata_d   = bus.i_rden ? (addr_ok ? rd_val : '0) : rddata_q;
    err_d      = (bus.i_rden & ~addr_ok) | (bus.i_wren & ~wr_acc);
    wr_pulse_d = wr_en_vec;
  end

  // Response registers; async reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdvalid_q  <= 1'b0;
      rddata_q   <= '0;
      err_q      <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      rdvalid_q  <= rdvalid_d;
      rddata_q   <= rddata_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign bus.o_rdvalid = rdvalid_q;
  assign bus.o_rddata  = rddata_q;
  assign bus.o_err     = err_q;
  assign o_wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_regmap_gen.sv
// Directed bench for regmap_gen: 8-bit default map plus a 32-bit instance for byte enables.
// Sticky status checks are compiled in when REGMAP_GEN_W1C_EN is defined.
module tb_regmap_gen;
  import regmap_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regmap_gen_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8))  b8 ();
  regmap_gen_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b32 ();

  logic [63:0]  ro8, rw8;
  logic [7:0]   wp8;
  logic [255:0] ro32, rw32;
  logic [7:0]   wp32;

  regmap_gen u8 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b8),
    .o_rw_regs(rw8), .i_ro_regs(ro8), .o_wr_pulse(wp8)
  );

  regmap_gen #(.DATA_WIDTH(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b32),
    .o_rw_regs(rw32), .i_ro_regs(ro32), .o_wr_pulse(wp32)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w8(input logic [3:0] a, input logic [7:0] d, input logic be);
    b8.i_addr = a; b8.i_wrdata = d; b8.i_be = be; b8.i_wren = 1'b1;
    tick();
    b8.i_wren = 1'b0;
  endtask

  task automatic r8(input logic [3:0] a, output logic [7:0] d, output logic v, output logic e);
    b8.i_addr = a; b8.i_rden = 1'b1;
    tick();
    b8.i_rden = 1'b0;
    d = b8.o_rddata; v = b8.o_rdvalid; e = b8.o_err;
  endtask

  task automatic w32(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b32.i_addr = a; b32.i_wrdata = d; b32.i_be = be; b32.i_wren = 1'b1;
    tick();
    b32.i_wren = 1'b0;
  endtask

  logic [7:0]  d8;
  logic [31:0] d32;
  logic        v, e;
  logic [7:0]  exp_rd [8];

  initial begin
    exp_rd = '{8'h00, 8'h11, 8'h00, 8'h33, 8'h00, 8'h55, 8'h00, 8'h77};
    b8.i_wren = 0; b8.i_rden = 0; b8.i_addr = 0; b8.i_wrdata = 0; b8.i_be = 0;
    b32.i_wren = 0; b32.i_rden = 0; b32.i_addr = 0; b32.i_wrdata = 0; b32.i_be = 0;
    // RO sources on odd slices; RW slices carry junk that must be ignored.
    ro8  = 64'h77EE_55EE_33EE_11EE;
    ro32 = '0;

    // Reset state
    tick(); tick();
    chk("rst rdvalid", b8.o_rdvalid, 1'b0);
    chk("rst rddata", b8.o_rddata, 8'h00);
    chk("rst err", b8.o_err, 1'b0);
    chk("rst wr_pulse", wp8, 8'h00);
    chk("rst rw_regs", rw8, 64'h0);
    chk("rst rw32", rw32[63:0], 64'h0);
    rst_n = 1'b1;
    tick();

    // Read all registers after reset
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pre rdvalid%0d", i), b8.o_rdvalid, 1'b0);
      r8(4'(i), d8, v, e);
      chk($sformatf("rd%0d data", i), d8, exp_rd[i]);
      chk($sformatf("rd%0d valid", i), v, 1'b1);
      chk($sformatf("rd%0d err", i), e, 1'b0);
      tick();
    end

    // Write 0x5A to register 2
    w8(4'd2, 8'h5A, 1'b1);
    chk("w2 pulse", wp8, 8'h04);
    chk("w2 err", b8.o_err, 1'b0);
    tick();
    chk("w2 pulse gone", wp8, 8'h00);
    chk("w2 rw_regs", rw8, 64'h0000_0000_005A_0000);
    r8(4'd2, d8, v, e);
    chk("r2 data", d8, 8'h5A);

    // Simultaneous read and write to the same address returns the old value
    b8.i_addr = 4'd2; b8.i_wrdata = 8'hC3; b8.i_be = 1'b1;
    b8.i_wren = 1'b1; b8.i_rden = 1'b1;
    tick();
    b8.i_wren = 1'b0; b8.i_rden = 1'b0;
    chk("rw same data", b8.o_rddata, 8'h5A);
    chk("rw same valid", b8.o_rdvalid, 1'b1);
    chk("rw same pulse", wp8, 8'h04);
    chk("rw same rw_regs", rw8, 64'h0000_0000_00C3_0000);

    // Back-to-back reads stream without bubbles
    b8.i_rden = 1'b1; b8.i_addr = 4'd2;
    tick();
    chk("b2b0 valid", b8.o_rdvalid, 1'b1);
    chk("b2b0 data", b8.o_rddata, 8'hC3);
    b8.i_addr = 4'd1;
    tick();
    chk("b2b1 valid", b8.o_rdvalid, 1'b1);
    chk("b2b1 data", b8.o_rddata, 8'h11);
    b8.i_rden = 1'b0;
    tick();
    chk("b2b end valid", b8.o_rdvalid, 1'b0);
    chk("b2b held data", b8.o_rddata, 8'h11);

    // Zero byte enables: pulse, no error, no change
    w8(4'd4, 8'hFF, 1'b0);
    chk("be0 pulse", wp8, 8'h10);
    chk("be0 err", b8.o_err, 1'b0);
    chk("be0 rw_regs", rw8, 64'h0000_0000_00C3_0000);

    // Out-of-range accesses
    w8(4'd9, 8'hFF, 1'b1);
    chk("wbad err", b8.o_err, 1'b1);
    chk("wbad pulse", wp8, 8'h00);
    chk("wbad rw_regs", rw8, 64'h0000_0000_00C3_0000);
    r8(4'd9, d8, v, e);
    chk("rbad data", d8, 8'h00);
    chk("rbad valid", v, 1'b1);
    chk("rbad err", e, 1'b1);
    tick();
    chk("rbad err gone", b8.o_err, 1'b0);

`ifdef REGMAP_GEN_W1C_EN
    // Sticky status on register 1
    ro8[15:8] = 8'h00;
    tick();
    w8(4'd1, 8'hFF, 1'b1);
    chk("w1c clr err", b8.o_err, 1'b0);
    chk("w1c clr pulse", wp8, 8'h02);
    r8(4'd1, d8, v, e);
    chk("w1c cleared", d8, 8'h00);
    ro8[15:8] = 8'h81;
    tick();
    ro8[15:8] = 8'h00;
    tick();
    r8(4'd1, d8, v, e);
    chk("w1c sticky", d8, 8'h81);
    w8(4'd1, 8'h01, 1'b1);
    r8(4'd1, d8, v, e);
    chk("w1c clr bit0", d8, 8'h80);
    ro8[15:8] = 8'h80;
    w8(4'd1, 8'h80, 1'b1);
    ro8[15:8] = 8'h00;
    r8(4'd1, d8, v, e);
    chk("w1c set wins", d8, 8'h80);
    chk("w1c rw slice", rw8[15:8], 8'h00);
`else
    // Write to an RO register is rejected
    w8(4'd3, 8'hFF, 1'b1);
    chk("wro err", b8.o_err, 1'b1);
    chk("wro pulse", wp8, 8'h00);
    chk("wro rw_regs", rw8, 64'h0000_0000_00C3_0000);
    r8(4'd3, d8, v, e);
    chk("rro data", d8, 8'h33);
    chk("rro err", e, 1'b0);
    ro8[31:24] = 8'h3C;
    r8(4'd3, d8, v, e);
    chk("rro live", d8, 8'h3C);
`endif

    // 32-bit byte-enabled merge
    w32(4'd0, 32'h1122_3344, 4'hF);
    w32(4'd0, 32'hAABB_CCDD, 4'b0101);
    chk("w32 err", b32.o_err, 1'b0);
    chk("w32 pulse", wp32, 8'h01);
    b32.i_addr = 4'd0; b32.i_rden = 1'b1;
    tick();
    b32.i_rden = 1'b0;
    d32 = b32.o_rddata;
    chk("r32 data", d32, 32'h11BB_33DD);
    chk("r32 valid", b32.o_rdvalid, 1'b1);
    chk("r32 rw_regs", rw32[31:0], 32'h11BB_33DD);

    // Reset during a read aborts it and restores reset values
    w8(4'd0, 8'h77, 1'b1);
    r8(4'd0, d8, v, e);
    chk("pre-rst data", d8, 8'h77);
    b8.i_addr = 4'd0; b8.i_rden = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("inrst rdvalid", b8.o_rdvalid, 1'b0);
    chk("inrst rddata", b8.o_rddata, 8'h00);
    chk("inrst err", b8.o_err, 1'b0);
    chk("inrst pulse", wp8, 8'h00);
    chk("inrst rw_regs", rw8, 64'h0);
    chk("inrst rw32", rw32[31:0], 32'h0);
    b8.i_rden = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst rdvalid%0d", i), b8.o_rdvalid, 1'b0);
    end
    chk("postrst rw_regs", rw8, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regmap_gen.md
REGMAP_GEN -- requirements
Module: regmap_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, word address width.
REQ-002 Parameter DATA_WIDTH, default 8, register width; SHALL be a multiple of 8.
REQ-003 Parameter NUM_REGS, default 8, register count; SHALL satisfy NUM_REGS <= 2**ADDR_WIDTH.
REQ-004 Parameter RO_MASK, default NUM_REGS'hAA, bit n set = register n is read-only (RO), clear = read-write (RW).
REQ-005 Parameter RW_RST, default 0, reset value applied to every RW register.
REQ-006 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-008 i_wren  in  1  write strobe, one access per high cycle.
REQ-009 i_rden  in  1  read strobe, one access per high cycle.
REQ-010 i_addr  in  ADDR_WIDTH  word address for read and write.
REQ-011 i_wrdata  in  DATA_WIDTH  write data.
REQ-012 i_be  in  DATA_WIDTH/8  byte enables; bit k qualifies i_wrdata byte k.
REQ-013 o_rdvalid  out  1  read data valid, one-cycle pulse.
REQ-014 o_rddata  out  DATA_WIDTH  read data, held until the next read.
REQ-015 o_err  out  1  access error pulse, aligned with o_rdvalid for reads and one cycle after i_wren for writes.
REQ-016 o_rw_regs  out  NUM_REGS*DATA_WIDTH  flattened register contents; register n occupies slice n; RO slices read 0.
REQ-017 i_ro_regs  in  NUM_REGS*DATA_WIDTH  flattened RO sources; RW slices are ignored.
REQ-018 o_wr_pulse  out  NUM_REGS  bit n pulses one cycle after any accepted write to register n.

Function
REQ-019 A write to an RW register SHALL update only the bytes whose i_be bit is set, at the rising edge where i_wren=1.
REQ-020 A read SHALL assert o_rdvalid exactly one cycle after i_rden=1 and drive o_rddata with the value as sampled at the i_rden edge.
REQ-021 Simultaneous i_wren and i_rden to the same address SHALL return the pre-write value and SHALL perform the write.
REQ-022 Any access with i_addr >= NUM_REGS SHALL assert o_err; a read returns 0, a write changes no state.
REQ-023 A write to an RO register SHALL assert o_err and change no state, unless REGMAP_GEN_W1C_EN is defined.
REQ-024 i_be = 0 on a write to a valid RW address SHALL leave data unchanged, still pulse o_wr_pulse, and not assert o_err.
REQ-025 Back-to-back reads on consecutive cycles SHALL produce o_rdvalid on consecutive cycles with no bubbles.

Reset
REQ-026 While i_rst_n=0: all RW registers = RW_RST, o_rdvalid=0, o_rddata=0, o_err=0, o_wr_pulse=0, and all sticky bits = 0.
REQ-027 Reset asserted mid-access SHALL abort the access; a read in flight SHALL not produce o_rdvalid after reset is released.

Configuration
REQ-028 With macro REGMAP_GEN_W1C_EN defined, each RO register SHALL be a sticky status register.
- Each bit is set on any cycle its i_ro_regs bit is 1.
- Each bit is cleared by writing 1 to it, byte-enable qualified.
- Such a write is accepted: o_wr_pulse fires and o_err stays 0.
- Set wins over a clear in the same cycle.
REQ-029 Without REGMAP_GEN_W1C_EN, an RO read SHALL return i_ro_regs as sampled at the i_rden edge, and no sticky storage exists.

Structure
REQ-030 A shared package regmap_gen_pkg SHALL hold the access-type enum (RW, RO, W1C) and a byte-lane count function.
REQ-031 One sub-module, regmap_gen_reg, SHALL implement a single byte-enabled register and be instantiated per register via generate.

Verification
REQ-032 Reset, then read all 8 registers -> RW read 0x00; RO read 0x11/0x33/0x55/0x77 when those values are driven; o_rdvalid 1 cycle after each i_rden.
REQ-033 Write 0x5A to address 2, then read address 2 -> 0x5A; o_wr_pulse[2] high for exactly 1 cycle; o_rw_regs slice 2 = 0x5A.
REQ-034 Write to address 3 (RO) and read address 9 with NUM_REGS=8 -> o_err pulses for both accesses, the read returns 0x00, and no state changes.
REQ-035 DATA_WIDTH=32: write 0xAABBCCDD with i_be=0101 over 0x11223344 -> 0x11BB33DD.
REQ-036 W1C_EN: pulse i_ro_regs slice 1 to 0x81, then drive it 0 -> reads 0x81; write 0x01 -> reads 0x80; set and clear of the same bit in one cycle -> bit stays 1.
REQ-037 Assert i_rst_n low the cycle after i_rden -> no o_rdvalid; all outputs 0 and RW registers back to RW_RST.
